// File: rtl/serial_adder_pkg.sv
// Purpose: shared types and constants for the bit-serial add/subtract engine.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package serial_adder_pkg;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Operation select values for the op input
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Largest supported operand width
    localparam int WIDTH_MAX = 32;

endpackage : serial_adder_pkg

// File: rtl/fulladder.sv
// Purpose: one-bit full-adder cell (a + b + c -> sum, carry).
// Latency: combinational, zero cycles.
// Backpressure: none; pure combinational logic.
// Ports: a, b, c (inputs, 1 bit); sum, carry (outputs, 1 bit).
module fulladder (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (a & c) | (b & c);

endmodule : fulladder

// File: rtl/serial_adder_ctrl.sv
// Purpose: bit-serial WIDTH-bit add/subtract, one bit per cycle LSB first through a single full-adder cell.
// Latency: WIDTH cycles from operand acceptance to out_valid; minimum issue interval WIDTH+2.
// Backpressure: result held in DONE until out_ready; operands accepted only in IDLE (no turnaround from DONE).
// Ports:
//   clk, rst            - rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   - operand handshake; a, b, cin, op captured on acceptance
//   out_valid/out_ready - result handshake; sum, cout registered and stable while waiting
//   busy                - high while an operation is running or its result is pending
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    generate
        if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
            $error("serial_adder_ctrl: WIDTH out of range 1..WIDTH_MAX");
        end
    endgenerate

    state_t            state_q;
    state_t            state_d;

    logic [WIDTH-1:0]  a_sr;
    logic [WIDTH-1:0]  b_sr;
    logic [WIDTH-1:0]  sum_sr;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              carry_q;
    logic [CW-1:0]     cnt_q;

    logic              fa_sum;
    logic              fa_carry;
    logic              accept;
    logic              last_bit;
    logic [WIDTH:0]    sum_ext;
    logic [WIDTH-1:0]  sum_shifted;

    // Bit slice: current LSBs of both operands plus the stored carry
    fulladder u_fa (
        .a     (a_sr[0]),
        .b     (b_sr[0]),
        .c     (carry_q),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    assign accept   = in_valid && (state_q == IDLE);
    assign last_bit = (state_q == RUN) && (cnt_q == LAST_BIT);

    // New sum bit enters at the MSB; widening first keeps this legal for WIDTH=1
    assign sum_ext     = {fa_sum, sum_sr};
    assign sum_shifted = sum_ext[WIDTH:1];

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RUN;
            RUN:     if (last_bit)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs decoded from the state register only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: in_ready  = 1'b0;
        endcase
    end

    // Datapath: operand/sum shift registers, carry FF, bit counter, result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sr    <= a;
            // Subtraction is a + ~b + 1: invert B here and seed the carry with 1
            b_sr    <= (op == OP_SUB) ? ~b : b;
            carry_q <= (op == OP_SUB) ? 1'b1 : cin;
            cnt_q   <= '0;
            sum_sr  <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else if (state_q == RUN) begin
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry_q <= fa_carry;
            sum_sr  <= sum_shifted;
            if (last_bit) begin
                // Result registers only move on DONE entry, so they stay stable under backpressure
                sum_q  <= sum_shifted;
                cout_q <= fa_carry;
            end else begin
                // Holding on the last bit keeps the counter from wrapping when WIDTH is a power of two
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Purpose: self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=1 against an arithmetic model.
// Latency: checks out_valid arrives exactly WIDTH cycles after acceptance.
// Backpressure: exercises out_ready low in DONE, in_valid pulses while busy, and reset mid-operation.
module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst;

    logic       in_valid8, in_ready8, cin8, op8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;

    logic       in_valid1, in_ready1, cin1, op1, out_valid1, out_ready1, cout1, busy1;
    logic [0:0] a1, b1, sum1;

    int vectors    = 0;
    int miscompares = 0;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .op        (op8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
        .busy      (busy8)
    );

    serial_adder_ctrl #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
        .op        (op1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .busy      (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: unsigned arithmetic modulo 2^w; SUB carry-out means "no borrow"
    function automatic logic [32:0] model(input int w, input logic [31:0] x, input logic [31:0] y,
                                          input logic c, input logic sub);
        longint mask;
        longint t;
        logic [32:0] r;
        mask = (64'd1 << w) - 1;
        if (!sub) begin
            t = longint'(x) + longint'(y) + longint'(c);
            r = {((t >> w) & 1) != 0, 32'(t & mask)};
        end else begin
            t = longint'(x) - longint'(y);
            r = {x >= y, 32'(t & mask)};
        end
        return r;
    endfunction

    // One WIDTH=8 operation: called just after a rising edge with the DUT in IDLE
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic icin,
                        input logic iop, input int hold, input bit perturb);
        logic [32:0] exp;
        int lat;
        exp = model(8, 32'(ia), 32'(ib), icin, iop);
        a8 = ia; b8 = ib; cin8 = icin; op8 = iop;
        in_valid8  = 1'b1;
        out_ready8 = (hold == 0);
        check_val("in_ready_idle", 32'(in_ready8), 1);
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        check_val("busy_run", 32'(busy8), 1);
        check_val("in_ready_run", 32'(in_ready8), 0);
        lat = 0;
        while (!out_valid8 && lat < 40) begin
            if (perturb) begin
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); op8 = 1'($urandom);
                in_valid8 = 1'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid8 = 1'b0;
        check_val("latency8", 32'(lat), 8);
        check_val("sum8", 32'(sum8), {24'd0, exp[7:0]});
        check_val("cout8", 32'(cout8), 32'(exp[32]));
        for (int i = 0; i < hold; i++) begin
            in_valid8 = 1'b1;
            a8 = 8'($urandom);
            @(posedge clk); #1;
            check_val("hold_valid", 32'(out_valid8), 1);
            check_val("hold_in_ready", 32'(in_ready8), 0);
            check_val("hold_sum", 32'(sum8), {24'd0, exp[7:0]});
            check_val("hold_cout", 32'(cout8), 32'(exp[32]));
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check_val("release_valid", 32'(out_valid8), 0);
        check_val("release_in_ready", 32'(in_ready8), 1);
        check_val("release_busy", 32'(busy8), 0);
    endtask

    task automatic run1(input logic ia, input logic ib, input logic icin, input logic iop);
        logic [32:0] exp;
        int lat;
        exp = model(1, 32'(ia), 32'(ib), icin, iop);
        a1 = ia; b1 = ib; cin1 = icin; op1 = iop;
        in_valid1  = 1'b1;
        out_ready1 = 1'b1;
        check_val("in_ready1", 32'(in_ready1), 1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
        a1 = ~a1; b1 = ~b1; cin1 = ~cin1; op1 = ~op1;
        lat = 0;
        while (!out_valid1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check_val("latency1", 32'(lat), 1);
        check_val("sum1", 32'(sum1), 32'(exp[0]));
        check_val("cout1", 32'(cout1), 32'(exp[32]));
        @(posedge clk); #1;
        check_val("in_ready1_back", 32'(in_ready1), 1);
    endtask

    initial begin
        rst = 1'b1;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = 1'b0; out_ready8 = 1'b1;
        in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; op1 = 1'b0; out_ready1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_in_ready", 32'(in_ready8), 1);
        check_val("rst_out_valid", 32'(out_valid8), 0);
        check_val("rst_busy", 32'(busy8), 0);
        check_val("rst_sum", 32'(sum8), 0);
        check_val("rst_cout", 32'(cout8), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run8(8'h5A, 8'h33, 1'b0, 1'b0, 0, 0);
        run8(8'hFF, 8'h01, 1'b0, 1'b0, 0, 0);
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0);
        run8(8'h10, 8'h01, 1'b0, 1'b1, 0, 0);
        run8(8'h10, 8'h01, 1'b1, 1'b1, 0, 1);
        run8(8'h01, 8'h02, 1'b1, 1'b1, 0, 0);
        run8(8'hC3, 8'h2D, 1'b1, 1'b0, 5, 1);

        // Held result is cleared by reset even while idle
        run8(8'hFF, 8'hFF, 1'b1, 1'b0, 0, 0);
        check_val("idle_sum_held", 32'(sum8), 32'hFF);
        #2 rst = 1'b1;
        #1;
        check_val("idle_rst_sum", 32'(sum8), 0);
        check_val("idle_rst_cout", 32'(cout8), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Reset during RUN bit 3 discards the operation
        a8 = 8'h77; b8 = 8'h99; cin8 = 1'b1; op8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'h00; b8 = 8'h00; op8 = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("midrun_rst_valid", 32'(out_valid8), 0);
        check_val("midrun_rst_busy", 32'(busy8), 0);
        check_val("midrun_rst_in_ready", 32'(in_ready8), 1);
        check_val("midrun_rst_sum", 32'(sum8), 0);
        check_val("midrun_rst_cout", 32'(cout8), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run8(8'h01, 8'h01, 1'b0, 1'b0, 0, 0);

        // Randomized operations with random backpressure and mid-RUN input noise
        for (int n = 0; n < 40; n++) begin
            run8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                 int'($urandom_range(0, 3)), 1'($urandom));
        end

        // WIDTH=1 instance: every input combination
        run1(1'b1, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 16; k++) begin
            logic [3:0] v;
            v = 4'(k);
            run1(v[0], v[1], v[2], v[3]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_adder_ctrl
